myfilter_dpc: RTL and testbench



---
 rtl/myfilter_pkg.sv | 53 +++++
 rtl/myfilter_dpc.sv | 77 +++++++
 tb/tb_myfilter_dpc.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/myfilter_pkg.sv
// Shared types and command constants for the FIR filter datapath and its controller.
package myfilter_pkg;

  localparam int NTAPS    = 5;
  localparam int CMEMSIZE = NTAPS;
  localparam int DMEMSIZE = NTAPS;
  localparam int CMEMAW   = $clog2(CMEMSIZE);
  localparam int DMEMAW   = $clog2(DMEMSIZE);
  localparam int DATABITS = 16;
  localparam int COEFBITS = 16;
  localparam int MULBITS  = DATABITS + COEFBITS;
  localparam int ACCBITS  = MULBITS + $clog2(NTAPS);

  typedef enum logic [4:0] {
    STOPPED = 5'd0,
    PROGRAM = 5'd1,
    EXTIN   = 5'd2,
    TAP0    = 5'd3,
    TAP1    = 5'd4,
    TAP2    = 5'd5,
    TAP3    = 5'd6,
    TAP4    = 5'd7,
    SAT     = 5'd8,
    EXTOUT  = 5'd9
  } dpc_fsm_t;

  typedef enum logic [1:0] {DMEM_NOP, DMEM_READ, DMEM_SHIFT, DMEM_CLEAR} dmem_cmd_t;
  typedef enum logic [1:0] {ALU_NOP, ALU_MU, ALU_ADMU, ALU_SATA} alu_cmd_t;
  typedef enum logic [1:0] {ACC_NOP, ACC_LOAD, ACC_CLEAR} acc_cmd_t;

  typedef struct packed {
    logic [CMEMAW-1:0] cmem_addr;
    dmem_cmd_t         dmem_cmd;
    logic [DMEMAW-1:0] dmem_addr;
    alu_cmd_t          alu_cmd;
    acc_cmd_t          acc_cmd;
    logic              extvalid;
  } dp_cmd_t;

  localparam int CMDBITS = $bits(dp_cmd_t);

  localparam dp_cmd_t CMD_NOP    = '{3'd0, DMEM_NOP,   3'd0, ALU_NOP,  ACC_NOP,   1'b0};
  localparam dp_cmd_t CMD_PROG   = '{3'd0, DMEM_CLEAR, 3'd0, ALU_NOP,  ACC_CLEAR, 1'b0};
  localparam dp_cmd_t CMD_EXTIN  = '{3'd0, DMEM_SHIFT, 3'd0, ALU_NOP,  ACC_CLEAR, 1'b0};
  localparam dp_cmd_t CMD_TAP0   = '{3'd0, DMEM_READ,  3'd0, ALU_MU,   ACC_LOAD,  1'b0};
  localparam dp_cmd_t CMD_TAP1   = '{3'd1, DMEM_READ,  3'd1, ALU_ADMU, ACC_LOAD,  1'b0};
  localparam dp_cmd_t CMD_TAP2   = '{3'd2, DMEM_READ,  3'd2, ALU_ADMU, ACC_LOAD,  1'b0};
  localparam dp_cmd_t CMD_TAP3   = '{3'd3, DMEM_READ,  3'd3, ALU_ADMU, ACC_LOAD,  1'b0};
  localparam dp_cmd_t CMD_TAP4   = '{3'd4, DMEM_READ,  3'd4, ALU_ADMU, ACC_LOAD,  1'b0};
  localparam dp_cmd_t CMD_SAT    = '{3'd0, DMEM_NOP,   3'd0, ALU_SATA, ACC_LOAD,  1'b0};
  localparam dp_cmd_t CMD_EXTOUT = '{3'd0, DMEM_NOP,   3'd0, ALU_NOP,  ACC_NOP,   1'b1};

endpackage

// File: rtl/myfilter_dpc.sv
// FIR datapath controller: one sample per pass through shift-in, five MACs,
// saturate and a single-cycle output strobe. Moore decode except the EXTIN handshake.
module myfilter_dpc
  import myfilter_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               enable_in,
  input  logic               i2c_busy_in,
  input  logic               extvalid_in,
  output logic               extready_out,
  output logic [CMDBITS-1:0] dp_cmd_out,
  output logic [4:0]         state_out
);

  dpc_fsm_t r_state;
  dpc_fsm_t w_next;
  dp_cmd_t  w_cmd;
  logic     w_ready;
  logic     w_accept;

  // Handshake: a sample is taken only in a cycle where extready_out and extvalid_in are both 1.
  assign w_ready  = (r_state == EXTIN) & enable_in & ~i2c_busy_in;
  assign w_accept = w_ready & extvalid_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= STOPPED;
    else     r_state <= w_next;
  end

  // Once TAP0 is entered the pass runs to EXTOUT regardless of enable/busy.
  always_comb begin
    w_next = STOPPED;
    case (r_state)
      STOPPED: begin
        if (i2c_busy_in)    w_next = PROGRAM;
        else if (enable_in) w_next = EXTIN;
        else                w_next = STOPPED;
      end
      PROGRAM: w_next = i2c_busy_in ? PROGRAM : STOPPED;
      EXTIN: begin
        if (!w_ready)      w_next = STOPPED;
        else if (w_accept) w_next = TAP0;
        else               w_next = EXTIN;
      end
      TAP0:    w_next = TAP1;
      TAP1:    w_next = TAP2;
      TAP2:    w_next = TAP3;
      TAP3:    w_next = TAP4;
      TAP4:    w_next = SAT;
      SAT:     w_next = EXTOUT;
      EXTOUT:  w_next = (enable_in & ~i2c_busy_in) ? EXTIN : STOPPED;
      default: w_next = STOPPED;
    endcase
  end

  always_comb begin
    w_cmd = CMD_NOP;
    case (r_state)
      PROGRAM: w_cmd = CMD_PROG;
      EXTIN:   w_cmd = w_accept ? CMD_EXTIN : CMD_NOP;
      TAP0:    w_cmd = CMD_TAP0;
      TAP1:    w_cmd = CMD_TAP1;
      TAP2:    w_cmd = CMD_TAP2;
      TAP3:    w_cmd = CMD_TAP3;
      TAP4:    w_cmd = CMD_TAP4;
      SAT:     w_cmd = CMD_SAT;
      EXTOUT:  w_cmd = CMD_EXTOUT;
      default: w_cmd = CMD_NOP;
    endcase
  end

  assign extready_out = w_ready;
  assign dp_cmd_out   = w_cmd;
  assign state_out    = r_state;

endmodule

// File: tb/tb_myfilter_dpc.sv
// Directed bench for myfilter_dpc: reset, programming, single pass, back-to-back
// throughput, busy during a pass, busy colliding with valid, async reset mid-pass.
module tb_myfilter_dpc;
  import myfilter_pkg::*;

  logic               clk;
  logic               rst;
  logic               enable_in;
  logic               i2c_busy_in;
  logic               extvalid_in;
  logic               extready_out;
  logic [CMDBITS-1:0] dp_cmd_out;
  logic [4:0]         state_out;

  int n_total;
  int n_bad;

  myfilter_dpc dut (
    .clk          (clk),
    .rst          (rst),
    .enable_in    (enable_in),
    .i2c_busy_in  (i2c_busy_in),
    .extvalid_in  (extvalid_in),
    .extready_out (extready_out),
    .dp_cmd_out   (dp_cmd_out),
    .state_out    (state_out)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic dp_cmd_t mk(input logic [2:0] ca, input dmem_cmd_t dc,
                                 input logic [2:0] da, input alu_cmd_t al,
                                 input acc_cmd_t ac, input logic ev);
    dp_cmd_t c;
    c.cmem_addr = ca;
    c.dmem_cmd  = dc;
    c.dmem_addr = da;
    c.alu_cmd   = al;
    c.acc_cmd   = ac;
    c.extvalid  = ev;
    return c;
  endfunction

  function automatic dp_cmd_t tap_exp(input int k);
    return mk(3'(k), DMEM_READ, 3'(k), (k == 0) ? ALU_MU : ALU_ADMU, ACC_LOAD, 1'b0);
  endfunction

  dp_cmd_t e_nop, e_prog, e_shift, e_sat, e_out;
  int acc_q[$];
  int ev_q[$];
  int rdy_viol;

  initial begin
    n_total = 0;
    n_bad   = 0;
    e_nop   = mk(3'd0, DMEM_NOP,   3'd0, ALU_NOP,  ACC_NOP,   1'b0);
    e_prog  = mk(3'd0, DMEM_CLEAR, 3'd0, ALU_NOP,  ACC_CLEAR, 1'b0);
    e_shift = mk(3'd0, DMEM_SHIFT, 3'd0, ALU_NOP,  ACC_CLEAR, 1'b0);
    e_sat   = mk(3'd0, DMEM_NOP,   3'd0, ALU_SATA, ACC_LOAD,  1'b0);
    e_out   = mk(3'd0, DMEM_NOP,   3'd0, ALU_NOP,  ACC_NOP,   1'b1);

    rst = 1'b1; enable_in = 1'b0; i2c_busy_in = 1'b0; extvalid_in = 1'b0;
    tick(); tick();
    chk("rst_state", 16'(state_out), 16'(STOPPED));
    chk("rst_cmd", 16'(dp_cmd_out), 16'(e_nop));
    chk("rst_ready", 16'(extready_out), 16'd0);
    rst = 1'b0;
    tick();
    chk("idle_state", 16'(state_out), 16'(STOPPED));

    // programming window of 10 cycles
    i2c_busy_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("prog_state", 16'(state_out), 16'(PROGRAM));
      chk("prog_cmd", 16'(dp_cmd_out), 16'(e_prog));
      chk("prog_ready", 16'(extready_out), 16'd0);
    end
    i2c_busy_in = 1'b0;
    tick();
    chk("prog_exit", 16'(state_out), 16'(STOPPED));

    // single sample pass
    enable_in = 1'b1;
    tick();
    chk("extin_state", 16'(state_out), 16'(EXTIN));
    chk("extin_ready", 16'(extready_out), 16'd1);
    chk("extin_idle_cmd", 16'(dp_cmd_out), 16'(e_nop));
    extvalid_in = 1'b1;
    #1;
    chk("accept_cmd", 16'(dp_cmd_out), 16'(e_shift));
    tick();
    extvalid_in = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("tap_state", 16'(state_out), 16'(16'(TAP0) + 16'(k)));
      chk("tap_cmd", 16'(dp_cmd_out), 16'(tap_exp(k)));
      chk("tap_ready", 16'(extready_out), 16'd0);
      tick();
    end
    chk("sat_state", 16'(state_out), 16'(SAT));
    chk("sat_cmd", 16'(dp_cmd_out), 16'(e_sat));
    tick();
    chk("out_state", 16'(state_out), 16'(EXTOUT));
    chk("out_cmd", 16'(dp_cmd_out), 16'(e_out));
    tick();
    chk("out_to_extin", 16'(state_out), 16'(EXTIN));
    tick();
    chk("extin_wait", 16'(state_out), 16'(EXTIN));

    // extvalid_in held for 40 cycles
    extvalid_in = 1'b1;
    rdy_viol = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (extready_out && extvalid_in) acc_q.push_back(i);
      if (dp_cmd_out[0]) ev_q.push_back(i);
      if (extready_out !== (state_out == 5'(EXTIN))) rdy_viol++;
      tick();
    end
    extvalid_in = 1'b0;
    chk("stream_accepts", 16'(acc_q.size()), 16'd5);
    chk("stream_strobes", 16'(ev_q.size()), 16'd5);
    chk("stream_ready_only_extin", 16'(rdy_viol), 16'd0);
    for (int j = 0; j < acc_q.size(); j++)
      chk("stream_accept_cycle", 16'(acc_q[j]), 16'(8 * j));
    for (int j = 0; j < ev_q.size(); j++)
      chk("stream_strobe_cycle", 16'(ev_q[j]), 16'(8 * j + 7));
    chk("stream_end_state", 16'(state_out), 16'(EXTIN));

    // busy rising in TAP1 does not abort the pass
    extvalid_in = 1'b1;
    #1;
    chk("busy_accept", 16'(dp_cmd_out), 16'(e_shift));
    tick();
    extvalid_in = 1'b0;
    tick();
    i2c_busy_in = 1'b1;
    #1;
    chk("busy_tap1", 16'(state_out), 16'(TAP1));
    chk("busy_tap1_cmd", 16'(dp_cmd_out), 16'(tap_exp(1)));
    tick(); tick(); tick();
    chk("busy_tap4", 16'(state_out), 16'(TAP4));
    tick();
    chk("busy_sat", 16'(state_out), 16'(SAT));
    tick();
    chk("busy_out_cmd", 16'(dp_cmd_out), 16'(e_out));
    tick();
    chk("busy_stopped", 16'(state_out), 16'(STOPPED));
    tick();
    chk("busy_program", 16'(state_out), 16'(PROGRAM));
    i2c_busy_in = 1'b0;
    tick();
    chk("busy_release", 16'(state_out), 16'(STOPPED));

    // valid and busy together in EXTIN
    tick();
    chk("coll_extin", 16'(state_out), 16'(EXTIN));
    extvalid_in = 1'b1;
    i2c_busy_in = 1'b1;
    #1;
    chk("coll_ready", 16'(extready_out), 16'd0);
    chk("coll_no_shift", 16'(dp_cmd_out), 16'(e_nop));
    tick();
    chk("coll_stopped", 16'(state_out), 16'(STOPPED));
    extvalid_in = 1'b0;
    i2c_busy_in = 1'b0;

    // asynchronous reset in the middle of TAP2
    tick();
    chk("rst2_extin", 16'(state_out), 16'(EXTIN));
    extvalid_in = 1'b1;
    tick();
    extvalid_in = 1'b0;
    tick(); tick();
    chk("rst2_tap2", 16'(state_out), 16'(TAP2));
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_state", 16'(state_out), 16'(STOPPED));
    chk("async_rst_cmd", 16'(dp_cmd_out), 16'(e_nop));
    chk("async_rst_ready", 16'(extready_out), 16'd0);
    tick();
    #2;
    rst = 1'b0;
    chk("rst_hold_no_strobe", 16'(dp_cmd_out[0]), 16'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
